// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_responder_pkg;

    // Data word width; byte lanes are not supported.
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // Word index of a byte address (drops the byte offset).
    function automatic logic [31:0] word_idx(input logic [31:0] addr);
        return {2'b00, addr[31:2]};
    endfunction

endpackage

// File: rtl/dmem_responder_sram.sv
// Single-port word array: write-first, one-cycle registered read, array not reset.
module dmem_responder_sram #(
    parameter int unsigned DEPTH  = 4096,
    parameter int unsigned DATA_W = 32,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_d, rdata_q;

    // Read port: a write returns the new data, otherwise the stored word; holds when idle.
    always_comb begin
        rdata_d = rdata_q;
        if (en) begin
            rdata_d = we ? wdata : mem[addr];
        end
    end

    // Array write and read-data register.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, inserts wait states,
// stalls the upstream pipeline and returns a one-cycle response.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DEPTH       = 4096,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_stall
);

    localparam int unsigned CntW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    dmem_state_t     state_d, state_q;
    logic [CntW-1:0] cnt_d, cnt_q;
    logic            wr_d, wr_q;
    logic            err_d, err_q;
    logic            resp_valid_d, resp_valid_q;

    logic [31:0]       idx;
    logic              req_err;
    logic              accept;
    logic [DATA_W-1:0] sram_rdata;

    // Address decode and error check on the incoming request.
    always_comb begin
        idx     = word_idx(32'(req_addr));
        req_err = (req_addr[1:0] != 2'b00) || (idx >= 32'(DEPTH));
        // Gated by rst so no array write can slip in while reset is held.
        accept  = (state_q == IDLE) && req_valid && !rst;
    end

    // Erroneous requests never touch the array, so a bad store cannot commit.
    dmem_responder_sram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_sram (
        .clk   (clk),
        .en    (accept && !req_err),
        .we    (req_wr),
        .addr  (idx[AW-1:0]),
        .wdata (req_wdata),
        .rdata (sram_rdata)
    );

    // Next-state logic for the FSM, wait counter and latched transaction.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_d         = wr_q;
        err_d        = err_q;
        resp_valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    wr_d  = req_wr;
                    err_d = req_err;
                    if (WAIT_STATES == 0) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CntW'(1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == CntW'(WAIT_STATES)) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state and registered response flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            wr_q         <= 1'b0;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_q         <= wr_d;
            err_q        <= err_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    // The SRAM read register holds the load data from the accept edge until RESP.
    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_valid_q && err_q;
    assign resp_rdata = (resp_valid_q && !wr_q && !err_q) ? sram_rdata : '0;
    assign mem_stall  = req_valid && (state_q != RESP);

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (WAIT_STATES=2 main instance, WAIT_STATES=0 second).
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        req_valid, req_wr, req_ready, resp_valid, resp_err, mem_stall;
    logic [15:0] req_addr;
    logic [31:0] req_wdata, resp_rdata;

    logic        z_req_valid, z_req_wr, z_req_ready, z_resp_valid, z_resp_err, z_mem_stall;
    logic [15:0] z_req_addr;
    logic [31:0] z_req_wdata, z_resp_rdata;

    int checks = 0;
    int errors = 0;
    int wait_visits = 0;

    always #5 clk = ~clk;

    dmem_responder #(
        .ADDR_W      (16),
        .DEPTH       (4096),
        .WAIT_STATES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_stall  (mem_stall)
    );

    dmem_responder #(
        .ADDR_W      (16),
        .DEPTH       (4096),
        .WAIT_STATES (0)
    ) dut0 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (z_req_valid),
        .req_wr     (z_req_wr),
        .req_addr   (z_req_addr),
        .req_wdata  (z_req_wdata),
        .req_ready  (z_req_ready),
        .resp_valid (z_resp_valid),
        .resp_rdata (z_resp_rdata),
        .resp_err   (z_resp_err),
        .mem_stall  (z_mem_stall)
    );

    // The zero-wait instance must never enter WAIT.
    always @(posedge clk) begin
        if (dut0.state_q == WAIT) wait_visits++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic logic o_ready(input bit z);
        return z ? z_req_ready : req_ready;
    endfunction
    function automatic logic o_rv(input bit z);
        return z ? z_resp_valid : resp_valid;
    endfunction
    function automatic logic o_err(input bit z);
        return z ? z_resp_err : resp_err;
    endfunction
    function automatic logic o_stall(input bit z);
        return z ? z_mem_stall : mem_stall;
    endfunction
    function automatic logic [31:0] o_rdata(input bit z);
        return z ? z_resp_rdata : resp_rdata;
    endfunction

    task automatic drive(input bit z, input logic v, input logic wr, input logic [15:0] a,
                         input logic [31:0] d);
        if (z) begin
            z_req_valid = v; z_req_wr = wr; z_req_addr = a; z_req_wdata = d;
        end else begin
            req_valid = v; req_wr = wr; req_addr = a; req_wdata = d;
        end
    endtask

    // One transaction; entered and left 1 ns after a rising edge with the DUT idle.
    task automatic txn(input bit z, input logic wr, input logic [15:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rdata, input logic exp_err, input string name);
        int lat;
        bit got;
        drive(z, 1'b1, wr, a, d);
        @(negedge clk);
        check({name, "_ready"}, 32'(o_ready(z)), 32'd1);
        check({name, "_stall"}, 32'(o_stall(z)), 32'd1);
        @(posedge clk); #1;
        drive(z, 1'b0, 1'b0, 16'h0000, 32'h0);
        lat = 1;
        got = 1'b0;
        while (lat <= 8) begin
            @(negedge clk);
            if (o_rv(z)) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
        if (!got) lat = 99;
        check({name, "_latency"}, 32'(lat), z ? 32'd1 : 32'd3);
        if (got) begin
            check({name, "_rdata"}, o_rdata(z), exp_rdata);
            check({name, "_err"}, 32'(o_err(z)), 32'(exp_err));
            @(posedge clk); #1;
            check({name, "_pulse"}, 32'(o_rv(z)), 32'd0);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    vec_t vecs[13];
    bit   exp_st[8];
    bit   exp_rv[8];
    int   n_rv;

    initial begin
        vecs[0]  = '{1'b1, 16'h0010, 32'hDEADBEEF, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 16'h0010, 32'h0000_0000, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 16'h0004, 32'hA5A50004, 32'h0000_0000, 1'b0};
        vecs[3]  = '{1'b0, 16'h0006, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[4]  = '{1'b0, 16'h0004, 32'h0000_0000, 32'hA5A50004, 1'b0};
        vecs[5]  = '{1'b1, 16'h0000, 32'h11110000, 32'h0000_0000, 1'b0};
        vecs[6]  = '{1'b1, 16'h4000, 32'hBAD0BAD0, 32'h0000_0000, 1'b1};
        vecs[7]  = '{1'b0, 16'h0000, 32'h0000_0000, 32'h11110000, 1'b0};
        vecs[8]  = '{1'b1, 16'h0012, 32'h0000FFFF, 32'h0000_0000, 1'b1};
        vecs[9]  = '{1'b0, 16'h0010, 32'h0000_0000, 32'hDEADBEEF, 1'b0};
        vecs[10] = '{1'b0, 16'hFFFC, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[11] = '{1'b1, 16'h3FFC, 32'h5A5A5A5A, 32'h0000_0000, 1'b0};
        vecs[12] = '{1'b0, 16'h3FFC, 32'h0000_0000, 32'h5A5A5A5A, 1'b0};
        exp_st = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_rv = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

        drive(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err", 32'(resp_err), 32'd0);
        check("rst_stall", 32'(mem_stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Table of single transactions on the WAIT_STATES=2 instance.
        for (int i = 0; i < 13; i++) begin
            txn(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].err,
                $sformatf("vec%0d", i));
        end

        // Back-to-back loads with req_valid held high; address change during WAIT.
        drive(1'b0, 1'b1, 1'b0, 16'h0000, 32'h0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("b2b_stall%0d", i), 32'(mem_stall), 32'(exp_st[i]));
            check($sformatf("b2b_rv%0d", i), 32'(resp_valid), 32'(exp_rv[i]));
            if (i == 3) check("b2b_rdata0", resp_rdata, 32'h11110000);
            if (i == 7) check("b2b_rdata1", resp_rdata, 32'hA5A50004);
            if (i == 1) req_addr = 16'h0004;
            @(posedge clk); #1;
        end
        drive(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);

        // Reset during WAIT after a store has been accepted.
        drive(1'b0, 1'b1, 1'b1, 16'h0020, 32'h12345678);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_ready", 32'(req_ready), 32'd1);
        check("midrst_resp_valid", 32'(resp_valid), 32'd0);
        check("midrst_rdata", resp_rdata, 32'd0);
        check("midrst_err", 32'(resp_err), 32'd0);
        check("midrst_stall", 32'(mem_stall), 32'd0);
        n_rv = 0;
        repeat (2) begin
            @(negedge clk);
            if (resp_valid) n_rv++;
        end
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (resp_valid) n_rv++;
        end
        check("midrst_no_resp", 32'(n_rv), 32'd0);
        @(posedge clk); #1;
        txn(1'b0, 1'b0, 16'h0020, 32'h0, 32'h12345678, 1'b0, "midrst_load");

        // Zero-wait instance: response on the cycle after accept.
        txn(1'b1, 1'b1, 16'h0008, 32'hCAFEF00D, 32'h0, 1'b0, "ws0_store");
        txn(1'b1, 1'b0, 16'h0008, 32'h0, 32'hCAFEF00D, 1'b0, "ws0_load");
        txn(1'b1, 1'b0, 16'h000A, 32'h0, 32'h0, 1'b1, "ws0_misaligned");
        check("ws0_no_wait", 32'(wait_visits), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
